// File: rtl/frame_loader.sv
// frame_loader: pipelined Wishbone write master that copies one picture frame, row by row,
// into a row-addressed display slave, with a single-entry request slot and bus-error abort.
module frame_loader #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int ROW_COUNT = 8,
  parameter int WB_ADDR_WIDTH = $clog2(ROW_COUNT),
  parameter int WB_SEL_WIDTH = WB_DATA_WIDTH / 8,
  parameter int PIC_COUNT = 4,
  parameter int PIC_W = $clog2(PIC_COUNT),
  parameter int MAX_OUTSTANDING = 4,
  parameter int LOAD_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_change,
  input  logic                     i_sel_valid,
  input  logic [PIC_W-1:0]         i_sel_pic,
  output logic [PIC_W-1:0]         o_pic_rd_pic,
  output logic [WB_ADDR_WIDTH-1:0] o_pic_rd_row,
  input  logic [WB_DATA_WIDTH-1:0] i_pic_rd_data,
  output logic [PIC_W-1:0]         o_pic_num,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [WB_ADDR_WIDTH-1:0] o_wb_addr,
  output logic [WB_SEL_WIDTH-1:0]  o_wb_sel,
  output logic [WB_DATA_WIDTH-1:0] o_wb_wdata,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_err
);
  localparam int CW = $clog2(ROW_COUNT + 1);
  localparam int MO = MAX_OUTSTANDING > ROW_COUNT ? ROW_COUNT : MAX_OUTSTANDING;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2;
  logic [1:0] state;
  logic r_change, pend, sel_in_range, sel_ok, req, start, beat, ack_ok;
  logic [PIC_W-1:0] pend_pic, last_req, pic, next_pic, req_pic;
  logic [CW-1:0] issued, acked, outstanding;
  // Out-of-range selects only exist when PIC_COUNT is not a power of two
  if (PIC_COUNT == 2 ** PIC_W) begin : g_full
    assign sel_in_range = 1'b1;
  end else begin : g_part
    assign sel_in_range = i_sel_pic < PIC_W'(PIC_COUNT);
  end
  always_comb begin
    sel_ok = i_sel_valid && sel_in_range;
    next_pic = (last_req == PIC_W'(PIC_COUNT - 1)) ? '0 : last_req + 1'b1;
    req = sel_ok || (i_change && !r_change);
    req_pic = sel_ok ? i_sel_pic : next_pic;
    start = (state == IDLE) && pend;
    outstanding = issued - acked;
    o_wb_cyc = (state != IDLE) && !reset;
    o_wb_stb = (state == LOAD) && (outstanding < CW'(MO)) && !reset;
    o_wb_we = o_wb_cyc;
    beat = o_wb_stb && !i_wb_stall;
    ack_ok = o_wb_cyc && i_wb_ack && (acked < CW'(ROW_COUNT));
  end
  assign o_busy = state != IDLE;
  assign o_pic_rd_pic = pic;
  assign o_pic_rd_row = WB_ADDR_WIDTH'(issued);
  assign o_wb_addr = WB_ADDR_WIDTH'(issued);
  assign o_wb_sel = '1;
  assign o_wb_wdata = i_pic_rd_data;
  // r_change keeps sampling through reset so a level held across reset is not an edge
  always_ff @(posedge clk) begin
    r_change <= i_change;
    if (reset) begin
      state <= IDLE;
      pend <= LOAD_ON_RESET != 0;
      pend_pic <= '0;
      last_req <= '0;
      pic <= '0;
      issued <= '0;
      acked <= '0;
      o_pic_num <= '0;
      o_done <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (req) begin
        pend <= 1'b1;
        pend_pic <= req_pic;
        last_req <= req_pic;
      end else if (start) begin
        pend <= 1'b0;
      end
      if (start) begin
        state <= LOAD;
        pic <= pend_pic;
        issued <= '0;
        acked <= '0;
        o_err <= 1'b0;
        o_pic_num <= pend_pic;
      end else if (o_wb_cyc && i_wb_err) begin
        state <= IDLE;
        o_err <= 1'b1;
      end else begin
        if (beat) issued <= issued + 1'b1;
        if (ack_ok) acked <= acked + 1'b1;
        if (beat && issued == CW'(ROW_COUNT - 1)) state <= DRAIN;
        if (state == DRAIN && acked == CW'(ROW_COUNT)) begin
          o_done <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule
